// File: rtl/csa_iterative_mantissa_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : csa_iterative_mantissa_multiplier
// Purpose  : Multi-cycle unsigned mantissa multiplier. Each ACCUM cycle folds
//            ROWS_PER_CYCLE partial-product rows into a registered Sum/Carry
//            pair through 3:2 compressors. A final carry-propagate add in
//            RESOLVE produces the 2*WIDTH-bit product.
// Ports    : Clock   - rising-edge clock
//            Reset   - asynchronous, active-high reset
//            Start   - request, sampled only while idle
//            MantA   - multiplicand, captured when Start is accepted
//            MantB   - multiplier, captured when Start is accepted
//            Busy    - high while an operation is in flight
//            Done    - one-cycle pulse, Product valid
//            Product - MantA*MantB, held until the next Done or Reset
// Revision : 1.0 - initial release
// ============================================================================
module csa_iterative_mantissa_multiplier #(
  parameter int WIDTH          = 24,
  parameter int ROWS_PER_CYCLE = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     MantA,
  input  logic [WIDTH-1:0]     MantB,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int c_prodW = 2 * WIDTH;
  // Row index reaches at most CYC*ROWS_PER_CYCLE <= 2*WIDTH-1.
  localparam int c_idxW  = $clog2(2 * WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2
  } stateT;

  stateT               r_state;
  stateT               w_nextState;

  logic [WIDTH-1:0]    r_mantA;
  logic [WIDTH-1:0]    r_mantB;
  logic [c_prodW-1:0]  r_sum;
  logic [c_prodW-1:0]  r_carry;
  logic [c_idxW-1:0]   r_rowIdx;
  logic [c_prodW-1:0]  r_product;
  logic                r_done;

  logic [c_prodW-1:0]  w_mantAExt;
  logic [c_prodW-1:0]  w_mantBExt;
  logic [c_prodW-1:0]  w_accSum;
  logic [c_prodW-1:0]  w_accCarry;
  logic [c_prodW-1:0]  w_ppRow;
  logic [c_prodW-1:0]  w_newSum;
  logic [c_idxW-1:0]   w_rowNum;
  logic                w_bBit;
  logic                w_lastAccum;

  assign w_mantAExt = {{WIDTH{1'b0}}, r_mantA};
  assign w_mantBExt = {{WIDTH{1'b0}}, r_mantB};

  // Last ACCUM cycle once this batch of rows reaches or passes WIDTH.
  assign w_lastAccum = ({{(32 - c_idxW){1'b0}}, r_rowIdx} + 32'(ROWS_PER_CYCLE))
                       >= 32'(WIDTH);

  // Carry-save reduction: each row is a 3:2 layer against the running
  // Sum/Carry pair, leaving exactly two vectors. Rows beyond WIDTH select a
  // zero multiplier bit from the zero-extended B, so they contribute nothing.
  // Carry vectors shift left by one and drop the MSB (mod 2^(2*WIDTH)).
  always_comb begin
    w_accSum   = r_sum;
    w_accCarry = r_carry;
    w_rowNum   = '0;
    w_bBit     = 1'b0;
    w_ppRow    = '0;
    w_newSum   = '0;
    for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
      w_rowNum   = r_rowIdx + c_idxW'(j);
      w_bBit     = |(w_mantBExt & (c_prodW'(1) << w_rowNum));
      w_ppRow    = w_bBit ? (w_mantAExt << w_rowNum) : '0;
      w_newSum   = w_accSum ^ w_accCarry ^ w_ppRow;
      w_accCarry = ((w_accSum & w_accCarry) |
                    (w_accSum & w_ppRow)    |
                    (w_accCarry & w_ppRow)) << 1;
      w_accSum   = w_newSum;
    end
  end

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and FSM outputs
  always_comb begin
    w_nextState = r_state;
    Busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_nextState = ACCUM;
        end
      end
      ACCUM: begin
        Busy = 1'b1;
        if (w_lastAccum) begin
          w_nextState = RESOLVE;
        end
      end
      RESOLVE: begin
        Busy        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mantA   <= '0;
      r_mantB   <= '0;
      r_sum     <= '0;
      r_carry   <= '0;
      r_rowIdx  <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_mantA  <= MantA;
            r_mantB  <= MantB;
            r_sum    <= '0;
            r_carry  <= '0;
            r_rowIdx <= '0;
          end
        end
        ACCUM: begin
          r_sum    <= w_accSum;
          r_carry  <= w_accCarry;
          r_rowIdx <= r_rowIdx + c_idxW'(ROWS_PER_CYCLE);
        end
        RESOLVE: begin
          r_product <= r_sum + r_carry;
          r_done    <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign Done    = r_done;
  assign Product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_csa_iterative_mantissa_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_iterative_mantissa_multiplier
// Purpose  : Scoreboard bench for csa_iterative_mantissa_multiplier. Stimulus
//            pushes expected products into per-instance queues; monitors pop
//            and compare whenever Done is seen. Covers the default 24/4
//            configuration plus 11/3 and 24/1 configurations.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_iterative_mantissa_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- default instance: WIDTH=24, ROWS_PER_CYCLE=4 ----------
  logic        rst0, start0, busy0, done0;
  logic [23:0] a0, b0;
  logic [47:0] prod0;
  logic [47:0] q0[$];

  csa_iterative_mantissa_multiplier #(.WIDTH(24), .ROWS_PER_CYCLE(4)) dut0 (
    .Clock(clk), .Reset(rst0), .Start(start0), .MantA(a0), .MantB(b0),
    .Busy(busy0), .Done(done0), .Product(prod0)
  );

  // ---------------- WIDTH=11, ROWS_PER_CYCLE=3 (CYC=4) --------------------
  logic        rstP, start1, busy1, done1;
  logic [10:0] a1, b1;
  logic [21:0] prod1;
  logic [21:0] q1[$];

  csa_iterative_mantissa_multiplier #(.WIDTH(11), .ROWS_PER_CYCLE(3)) dut1 (
    .Clock(clk), .Reset(rstP), .Start(start1), .MantA(a1), .MantB(b1),
    .Busy(busy1), .Done(done1), .Product(prod1)
  );

  // ---------------- WIDTH=24, ROWS_PER_CYCLE=1 (CYC=24) -------------------
  logic        start2, busy2, done2;
  logic [23:0] a2, b2;
  logic [47:0] prod2;
  logic [47:0] q2[$];

  csa_iterative_mantissa_multiplier #(.WIDTH(24), .ROWS_PER_CYCLE(1)) dut2 (
    .Clock(clk), .Reset(rstP), .Start(start2), .MantA(a2), .MantB(b2),
    .Busy(busy2), .Done(done2), .Product(prod2)
  );

  // ---------------- monitors ----------------------------------------------
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) check("done0_unexpected", 64'(done0), 64'd0);
      else                check("product0", 64'(prod0), 64'(q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) check("done1_unexpected", 64'(done1), 64'd0);
      else                check("product_w11_r3", 64'(prod1), 64'(q1.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) check("done2_unexpected", 64'(done2), 64'd0);
      else                check("product_w24_r1", 64'(prod2), 64'(q2.pop_front()));
    end
  end

  // ---------------- default-instance helpers ------------------------------
  // Called at a negedge; returns at the next negedge (first busy cycle).
  task automatic issue0(input logic [23:0] a, input logic [23:0] b,
                        input logic [47:0] expProd, input bit expectDone);
    start0 = 1'b1;
    a0     = a;
    b0     = b;
    if (expectDone) q0.push_back(expProd);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  // n0 = negedges already elapsed since Start was driven. Leaves the caller
  // at the negedge where Done is high.
  task automatic waitDone0(input string tag, input int reqN, input int n0);
    int n       = n0;
    int busyCnt = n0 - 1 + (busy0 ? 1 : 0);
    while (!done0 && n < 60) begin
      @(negedge clk);
      n++;
      if (busy0) busyCnt++;
    end
    check({tag, "_latency"}, 64'(n), 64'(reqN));
    check({tag, "_busy_cycles"}, 64'(busyCnt), 64'(reqN - 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; rstP = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    check("reset_product", 64'(prod0), 64'd0);
    check("reset_done",    64'(done0), 64'd0);
    check("reset_busy",    64'(busy0), 64'd0);
    rst0 = 1'b0; rstP = 1'b0;
    @(negedge clk);

    // Maximum operands: Busy 7 cycles, Done at edge E+7, single pulse.
    issue0(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1);
    waitDone0("max", 8, 1);
    @(negedge clk);
    check("max_done_pulse", 64'(done0), 64'd0);

    // Corner operands, same latency for zero.
    issue0(24'h800000, 24'h800000, 48'h400000000000, 1'b1);
    waitDone0("msb", 8, 1);
    issue0(24'h000000, 24'hABCDEF, 48'h000000000000, 1'b1);
    waitDone0("zero", 8, 1);
    issue0(24'h000001, 24'hABCDEF, 48'h000000ABCDEF, 1'b1);
    waitDone0("one", 8, 1);

    // Start with new operands during ACCUM is ignored.
    @(negedge clk);
    issue0(24'h000003, 24'h000007, 48'h000000000015, 1'b1);
    start0 = 1'b1; a0 = 24'hFFFFFF; b0 = 24'hFFFFFF;
    @(negedge clk);
    start0 = 1'b0;
    waitDone0("ignore", 8, 2);
    repeat (12) @(negedge clk);
    check("ignore_idle_busy", 64'(busy0), 64'd0);

    // Back-to-back: Start in the Done cycle is accepted.
    issue0(24'h000005, 24'h000007, 48'h000000000023, 1'b1);
    waitDone0("b2b_first", 8, 1);
    issue0(24'h000003, 24'h000005, 48'h00000000000F, 1'b1);
    waitDone0("b2b_second", 8, 1);
    @(negedge clk);

    // Abort: asynchronous reset mid-cycle during the 3rd ACCUM cycle.
    issue0(24'hFFFFFF, 24'hFFFFFF, 48'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_busy_before", 64'(busy0), 64'd1);
    #2;
    rst0 = 1'b1;
    #1;
    check("abort_product", 64'(prod0), 64'd0);
    check("abort_done",    64'(done0), 64'd0);
    check("abort_busy",    64'(busy0), 64'd0);
    @(negedge clk);
    rst0 = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_product_held", 64'(prod0), 64'd0);
    issue0(24'h000002, 24'h000002, 48'h000000000004, 1'b1);
    waitDone0("after_abort", 8, 1);

    // WIDTH=11, ROWS_PER_CYCLE=3: Done 5 edges after the accepting edge.
    for (int i = 0; i < 1000; i++) begin
      int n;
      logic [10:0] ra;
      logic [10:0] rb;
      ra = (i == 0) ? 11'h7FF : 11'($urandom);
      rb = (i == 0) ? 11'h7FF : 11'($urandom);
      start1 = 1'b1; a1 = ra; b1 = rb;
      q1.push_back(22'(ra) * 22'(rb));
      @(negedge clk);
      start1 = 1'b0;
      n = 1;
      while (!done1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("latency_w11_r3", 64'(n), 64'd6);
    end

    // WIDTH=24, ROWS_PER_CYCLE=1: Done 25 edges after the accepting edge.
    for (int i = 0; i < 1000; i++) begin
      int n;
      logic [23:0] ra;
      logic [23:0] rb;
      ra = (i == 0) ? 24'hFFFFFF : 24'($urandom);
      rb = (i == 0) ? 24'hFFFFFF : 24'($urandom);
      start2 = 1'b1; a2 = ra; b2 = rb;
      q2.push_back(48'(ra) * 48'(rb));
      @(negedge clk);
      start2 = 1'b0;
      n = 1;
      while (!done2 && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("latency_w24_r1", 64'(n), 64'd26);
    end

    repeat (3) @(negedge clk);
    check("pending_q0", 64'(q0.size()), 64'd0);
    check("pending_q1", 64'(q1.size()), 64'd0);
    check("pending_q2", 64'(q2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
